// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the four-way round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [NUM_REQ-1:0] req_vec_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Index of the requester that follows i in round-robin order.
  function automatic idx_t next_idx(input idx_t i);
    return i + idx_t'(1);
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// Rotating priority pick: first set request at or after ptr, modulo 4.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  idx_t cand;

  // NOTE: every output gets a default before the scan so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    idx  = ptr;
    cand = ptr;
    any  = |req;
    // Scan from the farthest offset down so the nearest hit is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) idx = cand;
    end
    pick = any ? (req_vec_t'(1) << idx) : '0;
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner selection for a shared 4:1 mux with a bounded grant hold.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               s0,
  output logic               s1,
  output logic               busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t            state, state_nxt;
  idx_t              ptr, ptr_nxt;
  idx_t              sel, sel_nxt;
  logic [CNT_W-1:0]  hold_cnt, hold_nxt;
  req_vec_t          gnt_nxt;
  logic              busy_nxt;

  idx_t              pick_ptr;
  req_vec_t          pick;
  idx_t              pick_idx;
  logic              pick_any;
  logic              others;

  // While granted, any re-pick starts just past the owner; the owner can
  // only win again if nobody else is asking.
  assign pick_ptr = (state == GRANT) ? next_idx(sel) : ptr;
  assign others   = |(req & ~gnt);

  rr_pick4 u_pick (
    .req  (req),
    .ptr  (pick_ptr),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    hold_nxt  = hold_cnt;
    gnt_nxt   = gnt;

    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = GRANT;
          gnt_nxt   = pick;
          sel_nxt   = pick_idx;
          hold_nxt  = '0;
        end
      end
      GRANT: begin
        if (!req[sel]) begin
          ptr_nxt  = next_idx(sel);
          hold_nxt = '0;
          if (pick_any) begin
            gnt_nxt = pick;
            sel_nxt = pick_idx;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
          end
        end else if (hold_cnt < HOLD_LAST) begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end else begin
          hold_nxt = '0;
          if (others) begin
            ptr_nxt = next_idx(sel);
            gnt_nxt = pick;
            sel_nxt = pick_idx;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == GRANT);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      sel      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      sel      <= sel_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      busy     <= busy_nxt;
    end
  end

  assign s0 = sel[0];
  assign s1 = sel[1];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench: four arbiter instances (MAX_HOLD 1,2,4,3) driven by directed tables
// and a randomized run compared against a queue-free behavioural model.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_v  [4];
  logic [3:0] req_v  [4];
  logic [3:0] gnt_v  [4];
  logic       s0_v   [4];
  logic       s1_v   [4];
  logic       busy_v [4];

  int n_err    = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  function automatic int mh_of(input int k);
    case (k)
      0: return 1;
      1: return 2;
      2: return 4;
      default: return 3;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mux4_rr_arbiter #(.MAX_HOLD(mh_of(g)), .CNT_W(4)) u_dut (
      .clk  (clk),
      .rst  (rst_v[g]),
      .req  (req_v[g]),
      .gnt  (gnt_v[g]),
      .s0   (s0_v[g]),
      .s1   (s1_v[g]),
      .busy (busy_v[g])
    );
  end

  // Behavioural model: owner as an integer (-1 = nobody), pointer and run
  // length as plain arithmetic.
  typedef struct {
    int         owner;
    int         ptr;
    int         cnt;
    logic [1:0] sel;
  } mstate_t;

  mstate_t m [4];

  function automatic int first_from(input logic [3:0] q, input int p);
    for (int k = 0; k < 4; k++)
      if (q[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic mstate_t step(input mstate_t s, input logic r,
                                   input logic [3:0] q, input int mh);
    mstate_t n;
    n = s;
    if (r) begin
      n.owner = -1; n.ptr = 0; n.cnt = 0; n.sel = 2'b00;
      return n;
    end
    if (s.owner < 0) begin
      if (q != 4'b0) begin
        n.owner = first_from(q, s.ptr);
        n.cnt   = 0;
      end
    end else if (!q[s.owner]) begin
      n.ptr   = (s.owner + 1) % 4;
      n.cnt   = 0;
      n.owner = (q != 4'b0) ? first_from(q, n.ptr) : -1;
    end else if (s.cnt < mh - 1) begin
      n.cnt = s.cnt + 1;
    end else begin
      n.cnt = 0;
      if ((q & ~(4'b0001 << s.owner)) != 4'b0) begin
        n.ptr   = (s.owner + 1) % 4;
        n.owner = first_from(q, n.ptr);
      end
    end
    if (n.owner >= 0) n.sel = 2'(n.owner);
    return n;
  endfunction

  always @(posedge clk)
    for (int k = 0; k < 4; k++)
      m[k] <= step(m[k], rst_v[k], req_v[k], mh_of(k));

  function automatic logic [6:0] model_out(input mstate_t s);
    logic [3:0] g;
    g = (s.owner < 0) ? 4'b0 : (4'b0001 << s.owner);
    return {g, s.sel, (s.owner >= 0)};
  endfunction

  function automatic logic [6:0] dut_out(input int k);
    return {gnt_v[k], s1_v[k], s0_v[k], busy_v[k]};
  endfunction

  task automatic check(input string name, input logic [6:0] act,
                       input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got gnt=%b sel=%b busy=%b, expected gnt=%b sel=%b busy=%b",
               name, act[6:3], act[2:1], act[0], exp[6:3], exp[2:1], exp[0]);
    end
  endtask

  typedef struct {
    string      name;
    int         inst;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string nm, input int inst, input logic r,
                              input logic [3:0] q, input logic [3:0] g,
                              input logic [1:0] s, input logic b);
    vec_t v;
    v.name = nm; v.inst = inst; v.rst = r; v.req = q;
    v.gnt = g; v.sel = s; v.busy = b;
    vecs.push_back(v);
  endfunction

  int wait_cnt [4];
  int max_wait;

  initial begin
    logic [3:0] rr_seq [9];
    logic [1:0] rr_sel [9];
    logic [3:0] q;
    logic       r;
    logic [3:0] g;
    logic       inv_ok;

    for (int k = 0; k < 4; k++) begin
      rst_v[k] = 1'b1;
      req_v[k] = 4'b0;
    end

    // Reset then single requester (MAX_HOLD=2)
    add("reset",        1, 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0);
    add("reset",        1, 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0);
    add("single_req",   1, 1'b0, 4'b0100, 4'b0100, 2'b10, 1'b1);
    add("idle_sel_hold",1, 1'b0, 4'b0000, 4'b0000, 2'b10, 1'b0);
    add("reset",        1, 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0);
    // Round-robin order with MAX_HOLD=2
    rr_seq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
               4'b0100, 4'b1000, 4'b1000, 4'b0001};
    rr_sel = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    for (int i = 0; i < 9; i++)
      add("rr_order", 1, 1'b0, 4'b1111, rr_seq[i], rr_sel[i], 1'b1);

    // Release handoff, lone hold, reset mid-grant (MAX_HOLD=4)
    add("reset",        2, 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0);
    add("own1",         2, 1'b0, 4'b0010, 4'b0010, 2'b01, 1'b1);
    add("own1_hold",    2, 1'b0, 4'b0011, 4'b0010, 2'b01, 1'b1);
    add("own1_hold",    2, 1'b0, 4'b0011, 4'b0010, 2'b01, 1'b1);
    add("handoff",      2, 1'b0, 4'b0001, 4'b0001, 2'b00, 1'b1);
    add("release_idle", 2, 1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0);
    add("reset",        2, 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0);
    for (int i = 0; i < 10; i++)
      add("lone_hold",  2, 1'b0, 4'b1000, 4'b1000, 2'b11, 1'b1);
    add("to_own1",      2, 1'b0, 4'b0010, 4'b0010, 2'b01, 1'b1);
    add("rst_mid",      2, 1'b1, 4'b0010, 4'b0000, 2'b00, 1'b0);
    add("regrant",      2, 1'b0, 4'b0010, 4'b0010, 2'b01, 1'b1);
    add("idle_sel_hold",2, 1'b0, 4'b0000, 4'b0000, 2'b01, 1'b0);

    // MAX_HOLD=1 rotates every cycle with two active requesters
    add("reset",        0, 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0);
    add("mh1_rot",      0, 1'b0, 4'b0011, 4'b0001, 2'b00, 1'b1);
    add("mh1_rot",      0, 1'b0, 4'b0011, 4'b0010, 2'b01, 1'b1);
    add("mh1_rot",      0, 1'b0, 4'b0011, 4'b0001, 2'b00, 1'b1);
    add("mh1_rot",      0, 1'b0, 4'b0011, 4'b0010, 2'b01, 1'b1);
    add("mh1_release",  0, 1'b0, 4'b0100, 4'b0100, 2'b10, 1'b1);
    add("mh1_lone",     0, 1'b0, 4'b0100, 4'b0100, 2'b10, 1'b1);
    add("mh1_idle",     0, 1'b0, 4'b0000, 4'b0000, 2'b10, 1'b0);

    @(negedge clk);
    foreach (vecs[i]) begin
      rst_v[vecs[i].inst] = vecs[i].rst;
      req_v[vecs[i].inst] = vecs[i].req;
      @(negedge clk);
      check(vecs[i].name, dut_out(vecs[i].inst),
            {vecs[i].gnt, vecs[i].sel, vecs[i].busy});
    end

    // Randomized fairness run on the MAX_HOLD=3 instance
    rst_v[3] = 1'b1;
    req_v[3] = 4'b0;
    @(negedge clk);
    rst_v[3] = 1'b0;
    for (int k = 0; k < 4; k++) wait_cnt[k] = 0;
    max_wait = 0;
    for (int c = 0; c < 2000; c++) begin
      q = 4'(~($urandom & $urandom));
      if ($urandom_range(0, 39) == 0) q = 4'b0000;
      r = ($urandom_range(0, 199) == 0);
      rst_v[3] = r;
      req_v[3] = q;
      @(negedge clk);
      check("rand_model", dut_out(3), model_out(m[3]));
      g = gnt_v[3];
      inv_ok = $onehot0(g) && ((g == 4'b0) || (g == (4'b0001 << {s1_v[3], s0_v[3]})))
               && (busy_v[3] == (g != 4'b0));
      check("rand_invariant", {6'b0, inv_ok}, 7'b1);
      for (int k = 0; k < 4; k++) begin
        if (q[k] && !r && !g[k]) wait_cnt[k]++;
        else wait_cnt[k] = 0;
        if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
      end
    end
    check("max_wait_le_12", {6'b0, (max_wait <= 12)}, 7'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
